dmem_lsu: RTL

- Load/store unit between the pipeline memory stage and the word-wide data RAM.
- Converts byte, halfword and word requests into word-aligned RAM accesses.
- Sub-word stores use read-modify-write.
- Loads are extracted by byte lane and zero- or sign-extended.
- Misaligned and illegal-size requests are flagged and never reach the RAM.

---
 rtl/dmem_lsu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline memory stage and a word-wide data RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module dmem_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 17
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [BUS_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [BUS_WIDTH-1:0]  ram_adr,
   output logic                  ram_memwrite,
   output logic [DATA_WIDTH-1:0] ram_writedata,
   input  logic [DATA_WIDTH-1:0] ram_readdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                  state_q, state_d;
   logic [BUS_WIDTH-1:0]    addr_q, addr_d;
   logic                    write_q, write_d;
   logic [1:0]              size_q, size_d;
   logic                    signed_q, signed_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   buf_q, buf_d;
   logic                    accept;

   // Replace the addressed byte/half lanes of the buffered word with store data.
   function automatic logic [DATA_WIDTH-1:0] merge_word(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [1:0]            size,
      input logic [1:0]            lane
   );
      logic [DATA_WIDTH-1:0] w;
      w = old_word;
      case (size)
         2'd0: begin
            case (lane)
               2'd0:    w[7:0]   = wdata[7:0];
               2'd1:    w[15:8]  = wdata[7:0];
               2'd2:    w[23:16] = wdata[7:0];
               default: w[31:24] = wdata[7:0];
            endcase
         end
         2'd1: begin
            if (lane[1]) w[31:16] = wdata[15:0];
            else         w[15:0]  = wdata[15:0];
         end
         default: w = wdata;
      endcase
      return w;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            size,
      input logic [1:0]            lane,
      input logic                  sgn
   );
      logic [7:0]            b;
      logic [15:0]           h;
      logic [DATA_WIDTH-1:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      write_d       = write_q;
      size_d        = size_q;
      signed_d      = signed_q;
      err_d         = err_q;
      wdata_d       = wdata_q;
      buf_d         = buf_q;
      req_ready     = (state_q == IDLE) && reset_n;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      resp_err      = 1'b0;
      ram_adr       = '0;
      ram_memwrite  = 1'b0;
      ram_writedata = '0;
      accept        = req_valid && req_ready;

      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = req_addr;
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               wdata_d  = req_wdata;
               buf_d    = '0;
               err_d    = (req_size == 2'd3) ||
                          (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'b00);
               if (err_d)                             state_d = RESP;
               else if (req_write && req_size == 2'd2) state_d = WRITE;
               else                                   state_d = READ;
            end
         end
         READ: begin
            ram_adr = {addr_q[BUS_WIDTH-1:2], 2'b00};
            // Stores keep the raw word for merging; loads keep the final result.
            buf_d   = write_q ? ram_readdata
                              : extract_load(ram_readdata, size_q, addr_q[1:0], signed_q);
            state_d = write_q ? WRITE : RESP;
         end
         WRITE: begin
            ram_adr       = {addr_q[BUS_WIDTH-1:2], 2'b00};
            ram_memwrite  = 1'b1;
            ram_writedata = merge_word(buf_q, wdata_q, size_q, addr_q[1:0]);
            state_d       = RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (write_q || err_q) ? '0 : buf_q;
            state_d    = IDLE;
         end
      endcase

      if (!reset_n) begin
         resp_valid    = 1'b0;
         resp_rdata    = '0;
         resp_err      = 1'b0;
         ram_adr       = '0;
         ram_memwrite  = 1'b0;
         ram_writedata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= '0;
         buf_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         err_q    <= err_d;
         wdata_q  <= wdata_d;
         buf_q    <= buf_d;
      end
   end

endmodule
